// File: rtl/sobel_pkg.sv
// Shared types and widths for the Sobel 3x3 window generator.
// Window element (r,c) lives at bits [PIX_W*(3*r+c) +: PIX_W].
package sobel_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_W = 72;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } sobel_state_t;

    function automatic int win_lsb(input int r, input int c);
        return PIX_W * (3 * r + c);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage: single-port RAM, read-before-write, DEPTH x PIX_W.
// Combinational read of the addressed entry (old data); write lands on the clock edge.
// No flow control: the owner qualifies wr_en with its own accept strobe.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [PIX_W-1:0]         wr_dat,
    output logic [PIX_W-1:0]         rd_dat
);

    logic [PIX_W-1:0] mem [DEPTH];

    assign rd_dat = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream -> 3x3 window stream; win_out/win_valid registered one cycle after the pixel.
// No backpressure: every pixel_valid cycle is consumed. Optional sticky frame_err via SOBEL_WIN_FRAME_ERR_EN.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             pixel_valid,
    input  logic             sof,
    output logic [WIN_W-1:0] win_out,
    output logic             win_valid,
    output logic             frame_err
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    sobel_state_t     state;
    logic [CW-1:0]    col_cnt;
    logic [RW-1:0]    row_cnt;

    logic             in_frame;
    logic             accept;
    logic [CW-1:0]    cur_col;
    logic [RW-1:0]    cur_row;
    logic [RW-1:0]    next_row;
    logic             col_last;
    logic             row_last;
    logic             emit;

    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;
    logic [PIX_W-1:0] new_col [3];
    logic [PIX_W-1:0] tap     [3][2];
    logic [WIN_W-1:0] win_nxt;

    // sof restarts the frame from any state, so it also forces position (0,0).
    assign in_frame = (state == FILL) || (state == STREAM);
    assign accept   = pixel_valid && (sof || in_frame);
    assign cur_col  = sof ? '0 : col_cnt;
    assign cur_row  = sof ? '0 : row_cnt;
    assign next_row = cur_row + RW'(1);
    assign col_last = (cur_col == CW'(IMG_WIDTH - 1));
    assign row_last = (cur_row == RW'(IMG_HEIGHT - 1));
    assign emit     = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

    // lb0 holds line R-1, lb1 holds line R-2; lb1 is fed from lb0's old entry.
    sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
        .clk    (clk),
        .wr_en  (accept),
        .addr   (cur_col),
        .wr_dat (pixel_in),
        .rd_dat (lb0_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk    (clk),
        .wr_en  (accept),
        .addr   (cur_col),
        .wr_dat (lb0_rd),
        .rd_dat (lb1_rd)
    );

    assign new_col[0] = lb1_rd;
    assign new_col[1] = lb0_rd;
    assign new_col[2] = pixel_in;

    always_comb begin
        win_nxt = '0;
        for (int r = 0; r < 3; r++) begin
            win_nxt[win_lsb(r, 0) +: PIX_W] = tap[r][0];
            win_nxt[win_lsb(r, 1) +: PIX_W] = tap[r][1];
            win_nxt[win_lsb(r, 2) +: PIX_W] = new_col[r];
        end
    end

    // Column taps carry stale data across a line wrap, but emit needs C>=2 so they are refilled first.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                tap[r][0] <= tap[r][1];
                tap[r][1] <= new_col[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col_cnt   <= '0;
            row_cnt   <= '0;
            win_valid <= 1'b0;
            win_out   <= '0;
        end else begin
            win_valid <= emit;
            if (emit) begin
                win_out <= win_nxt;
            end
            if (accept) begin
                if (col_last) begin
                    col_cnt <= '0;
                    if (row_last) begin
                        row_cnt <= '0;
                        state   <= DONE;
                    end else begin
                        row_cnt <= next_row;
                        state   <= (next_row >= RW'(2)) ? STREAM : FILL;
                    end
                end else begin
                    col_cnt <= cur_col + CW'(1);
                    row_cnt <= cur_row;
                    state   <= (cur_row >= RW'(2)) ? STREAM : FILL;
                end
            end
        end
    end

`ifdef SOBEL_WIN_FRAME_ERR_EN
    logic err_q;

    // Short frame (sof mid-frame) or a stray pixel outside any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (pixel_valid && (sof ? in_frame : !in_frame)) begin
            err_q <= 1'b1;
        end
    end

    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen at 8x6 with pixel = row*16+col; frame-level model plus literal checks.
module tb_sobel_window_gen;

    localparam int W = 8;
    localparam int H = 6;
`ifdef SOBEL_WIN_FRAME_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic        sof;
    logic [71:0] win_out;
    logic        win_valid;
    logic        frame_err;

    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .sof         (sof),
        .win_out     (win_out),
        .win_valid   (win_valid),
        .frame_err   (frame_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] el(input logic [71:0] w, input int r, input int c);
        return w[8*(3*r+c) +: 8];
    endfunction

    // Frame model: an image array filled as pixels arrive, windows cut straight from it.
    logic        m_in_frame = 1'b0;
    int          m_r = 0;
    int          m_c = 0;
    logic [7:0]  img [H][W];
    logic        m_vld = 1'b0;
    logic [71:0] m_win = '0;
    logic        m_err = 1'b0;
    logic [7:0]  prev_in = '0;

    always @(posedge clk) begin
        prev_in = pixel_in;
        if (rst) begin
            m_in_frame = 1'b0;
            m_vld      = 1'b0;
            m_win      = '0;
            m_err      = 1'b0;
        end else begin
            m_vld = 1'b0;
            if (pixel_valid) begin
                if (sof) begin
                    if (m_in_frame && ERR_EN) m_err = 1'b1;
                    m_in_frame = 1'b1;
                    m_r = 0;
                    m_c = 0;
                end else if (!m_in_frame && ERR_EN) begin
                    m_err = 1'b1;
                end
                if (m_in_frame) begin
                    img[m_r][m_c] = pixel_in;
                    if (m_r >= 2 && m_c >= 2) begin
                        m_vld = 1'b1;
                        for (int r = 0; r < 3; r++)
                            for (int c = 0; c < 3; c++)
                                m_win[8*(3*r+c) +: 8] = img[m_r-2+r][m_c-2+c];
                    end
                    m_c++;
                    if (m_c == W) begin
                        m_c = 0;
                        m_r++;
                        if (m_r == H) m_in_frame = 1'b0;
                    end
                end
            end
        end
    end

    logic        chk_en = 1'b0;
    logic        prev_vld = 1'b0;
    int          consec = 0;
    logic [71:0] dut_log [$];
    logic [7:0]  src_log [$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("win_valid", {71'd0, win_valid}, {71'd0, m_vld});
            chk("win_out", win_out, m_win);
            chk("frame_err", {71'd0, frame_err}, {71'd0, m_err});
            if (win_valid) begin
                dut_log.push_back(win_out);
                src_log.push_back(prev_in);
            end
            if (win_valid && prev_vld) consec++;
            prev_vld = win_valid;
        end
    end

    task automatic send(input logic [7:0] p, input logic s, input int gap);
        pixel_valid = 1'b1;
        pixel_in    = p;
        sof         = s;
        @(negedge clk);
        pixel_valid = 1'b0;
        sof         = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input int gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(8'(r*16 + c), (r == 0 && c == 0), gap);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    logic [71:0] ref_log [$];
    int          hits;
    int          idx;

    initial begin
        rst         = 1'b1;
        pixel_valid = 1'b0;
        sof         = 1'b0;
        pixel_in    = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst win_valid", {71'd0, win_valid}, 72'd0);
        chk("rst win_out", win_out, 72'd0);
        chk("rst frame_err", {71'd0, frame_err}, 72'd0);
        rst = 1'b0;
        @(negedge clk);

        // Continuous frame
        dut_log.delete(); src_log.delete();
        send_frame(0);
        chk("t1 count", 72'(dut_log.size()), 72'd24);
        chk("t1 first e00", {64'd0, el(dut_log[0], 0, 0)}, 72'h00);
        chk("t1 first e22", {64'd0, el(dut_log[0], 2, 2)}, 72'h22);
        chk("t1 first src", {64'd0, src_log[0]}, 72'h22);
        chk("t1 last e22", {64'd0, el(dut_log[23], 2, 2)}, 72'h57);
        chk("t1 frame_err", {71'd0, frame_err}, 72'd0);
        hits = 0;
        idx  = -1;
        foreach (src_log[i]) begin
            if (src_log[i] == 8'h30 || src_log[i] == 8'h31) hits++;
            if (src_log[i] == 8'h32) idx = i;
        end
        chk("row wrap no window", 72'(hits), 72'd0);
        chk("row wrap 0x32 seen", {71'd0, idx >= 0}, 72'd1);
        if (idx >= 0) chk("row wrap e00", {64'd0, el(dut_log[idx], 0, 0)}, 72'h10);
        ref_log = dut_log;

        // Same frame with pixel_valid toggling
        dut_log.delete(); src_log.delete();
        consec = 0;
        send_frame(1);
        chk("t2 count", 72'(dut_log.size()), 72'd24);
        chk("t2 back-to-back", 72'(consec), 72'd0);
        for (int i = 0; i < 24 && i < dut_log.size(); i++)
            chk($sformatf("t2 win %0d", i), dut_log[i], ref_log[i]);

        // Non-sof pixel after DONE
        dut_log.delete(); src_log.delete();
        send(8'h99, 1'b0, 2);
        chk("done no window", 72'(dut_log.size()), 72'd0);
        chk("done frame_err", {71'd0, frame_err}, {71'd0, ERR_EN});

        // sof re-asserted at (3,4)
        pulse_rst();
        dut_log.delete(); src_log.delete();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < W; c++)
                if (r < 3 || c < 4) send(8'(r*16 + c), (r == 0 && c == 0), 0);
        repeat (2) @(negedge clk);
        chk("short old windows", 72'(dut_log.size()), 72'd8);
        dut_log.delete(); src_log.delete();
        send_frame(0);
        chk("short new count", 72'(dut_log.size()), 72'd24);
        chk("short first src", {64'd0, src_log[0]}, 72'h22);
        chk("short first e00", {64'd0, el(dut_log[0], 0, 0)}, 72'h00);
        chk("short frame_err", {71'd0, frame_err}, {71'd0, ERR_EN});

        // rst at (4,1) with pixel_valid high
        pulse_rst();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < W; c++)
                if (r < 4 || c < 1) send(8'(r*16 + c), (r == 0 && c == 0), 0);
        rst         = 1'b1;
        pixel_valid = 1'b1;
        pixel_in    = 8'h41;
        @(negedge clk);
        chk("rst mid win_valid", {71'd0, win_valid}, 72'd0);
        chk("rst mid win_out", win_out, 72'd0);
        rst         = 1'b0;
        pixel_valid = 1'b0;
        @(negedge clk);
        dut_log.delete(); src_log.delete();
        for (int i = 0; i < 5; i++) send(8'(8'h42 + i), 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("rst ignored pixels", 72'(dut_log.size()), 72'd0);
        send_frame(0);
        chk("rst frame count", 72'(dut_log.size()), 72'd24);
        chk("rst frame first e22", {64'd0, el(dut_log[0], 2, 2)}, 72'h22);
        chk("rst frame last e22", {64'd0, el(dut_log[23], 2, 2)}, 72'h57);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
